fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined AArch64 core. Holds the program counter and drives the instruction-memory address. Computes the sequential PC and the PC-relative branch target with two 64-bit ripple adders, then registers the fetched instruction into the IF/ID pipeline register. Consumes adder results directly, accepts stall and redirect from the hazard and branch logic, and halts on a misaligned redirect.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/adder_64.sv | 20 ++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// No logic here; imported by fetch_stage and adder_64.
package fetch_pkg;

  localparam logic [31:0] INSTR_NOP   = 32'hD503201F;
  localparam int          INSTR_BYTES = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
  } ifid_t;

  // IF/ID contents after reset or a flush: empty slot holding a NOP.
  localparam ifid_t IFID_EMPTY = '{valid: 1'b0, pc: 64'h0, instr: INSTR_NOP};

endpackage

// File: rtl/adder_64.sv
// 64-bit ripple-carry adder, purely combinational, sum mod 2^64.
// Zero latency; no flow control, carry-out is dropped.
module adder_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum
);

  logic c;

  always_comb begin
    c   = 1'b0;
    sum = '0;
    for (int i = 0; i < 64; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, sequential/branch adders, IF/ID register.
// One-cycle fetch latency; stall holds PC and IF/ID, redirect flushes and wins over stall.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        br_use_reg,
  input  logic [63:0] br_base,
  input  logic [63:0] br_offset,
  input  logic [63:0] br_reg,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        ifid_valid,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        fetch_fault
);

  fetch_state_t state;
  logic [63:0]  pc;
  ifid_t        ifid_q;
  logic         fault_q;

  logic [63:0]  pc_inc;
  logic [63:0]  br_sum;
  logic [63:0]  target;
  logic         target_misaligned;

  // The two offset bits shifted out by the word scaling are intentionally dropped.
  logic unused_offset_hi;
  assign unused_offset_hi = ^br_offset[63:62];

  adder_64 u_pc_inc (
    .a   (pc),
    .b   (64'(INSTR_BYTES)),
    .sum (pc_inc)
  );

  adder_64 u_br_tgt (
    .a   (br_base),
    .b   ({br_offset[61:0], 2'b00}),
    .sum (br_sum)
  );

  always_comb begin
    target            = br_use_reg ? br_reg : br_sum;
    target_misaligned = |target[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      state   <= RUN;
      ifid_q  <= IFID_EMPTY;
      fault_q <= 1'b0;
    end else begin
      case (state)
        FAULT: begin
          ifid_q  <= IFID_EMPTY;
          fault_q <= 1'b1;
        end
        default: begin
          if (br_taken) begin
            ifid_q <= IFID_EMPTY;
            if (target_misaligned) begin
              state   <= FAULT;
              fault_q <= 1'b1;
            end else begin
              pc <= target;
            end
          end else if (!stall) begin
            pc     <= pc_inc;
            ifid_q <= '{valid: 1'b1, pc: pc, instr: imem_instr};
          end
        end
      endcase
    end
  end

  assign imem_addr   = pc;
  assign ifid_valid  = ifid_q.valid;
  assign ifid_pc     = ifid_q.pc;
  assign ifid_instr  = ifid_q.instr;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table of per-cycle vectors through a scoreboard queue,
// plus a hand-written redirect sequence checking imem_addr stability within a cycle.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [63:0] RPC = 64'h1000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic        br_use_reg;
  logic [63:0] br_base;
  logic [63:0] br_offset;
  logic [63:0] br_reg;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_use_reg  (br_use_reg),
    .br_base     (br_base),
    .br_offset   (br_offset),
    .br_reg      (br_reg),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .ifid_valid  (ifid_valid),
    .ifid_pc     (ifid_pc),
    .ifid_instr  (ifid_instr),
    .fetch_fault (fetch_fault)
  );

  // Instruction memory model: word depends on its address.
  assign imem_instr = 32'hAAAA0000 + imem_addr[31:0];

  function automatic logic [31:0] w(input logic [63:0] a);
    return 32'hAAAA0000 + a[31:0];
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst, stl, br, ur;
    logic [63:0] base, off, breg;
    logic [63:0] addr;
    logic        v;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        f;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic        v;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        f;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input logic rst, input logic stl, input logic br, input logic ur,
                     input logic [63:0] base, input logic [63:0] off, input logic [63:0] breg,
                     input logic [63:0] addr, input logic v, input logic [63:0] pc,
                     input logic [31:0] instr, input logic f);
    vec_t x;
    x = '{rst, stl, br, ur, base, off, breg, addr, v, pc, instr, f};
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sample(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".imem_addr"},   imem_addr,          e.addr);
    chk({tag, ".ifid_valid"},  64'(ifid_valid),    64'(e.v));
    chk({tag, ".ifid_pc"},     ifid_pc,            e.pc);
    chk({tag, ".ifid_instr"},  64'(ifid_instr),    64'(e.instr));
    chk({tag, ".fetch_fault"}, 64'(fetch_fault),   64'(e.f));
  endtask

  task automatic push_exp(input logic [63:0] addr, input logic v, input logic [63:0] pc,
                          input logic [31:0] instr, input logic f);
    exp_t e;
    e = '{addr, v, pc, instr, f};
    sb.push_back(e);
  endtask

  localparam logic [63:0] X64 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] MAXW = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    reset = 1'b0; stall = 1'b0; br_taken = 1'b0; br_use_reg = 1'b0;
    br_base = '0; br_offset = '0; br_reg = '0;

    //   rst stl br ur base          off                     breg      -> addr   v  pc        instr          f
    add(1, 0, 0, 0, X64,          X64,                    X64,       RPC,     0, 64'h0,    INSTR_NOP,     0);
    add(0, 0, 0, 0, X64,          X64,                    X64,       64'h1004, 1, 64'h1000, w(64'h1000),  0);
    add(0, 0, 0, 1, X64,          X64,                    X64,       64'h1008, 1, 64'h1004, w(64'h1004),  0);
    add(0, 0, 0, 0, X64,          X64,                    X64,       64'h100C, 1, 64'h1008, w(64'h1008),  0);
    add(0, 0, 1, 1, X64,          X64,                    MAXW,      MAXW,     0, 64'h0,    INSTR_NOP,    0);
    add(0, 0, 0, 0, X64,          X64,                    X64,       64'h0,    1, MAXW,     32'hAAA9FFFC, 0);
    add(0, 0, 0, 0, X64,          X64,                    X64,       64'h4,    1, 64'h0,    32'hAAAA0000, 0);
    add(0, 1, 1, 0, 64'h2000,     64'hFFFF_FFFF_FFFF_FFFE, X64,      64'h1FF8, 0, 64'h0,    INSTR_NOP,    0);
    add(0, 0, 0, 0, X64,          X64,                    X64,       64'h1FFC, 1, 64'h1FF8, w(64'h1FF8),  0);
    add(0, 0, 1, 1, X64,          X64,                    64'h3C,    64'h3C,   0, 64'h0,    INSTR_NOP,    0);
    add(0, 0, 0, 0, X64,          X64,                    X64,       64'h40,   1, 64'h3C,   w(64'h3C),    0);
    add(0, 1, 0, 1, X64,          X64,                    64'h3001,  64'h40,   1, 64'h3C,   w(64'h3C),    0);
    add(0, 1, 0, 0, X64,          X64,                    X64,       64'h40,   1, 64'h3C,   w(64'h3C),    0);
    add(0, 1, 0, 0, X64,          X64,                    X64,       64'h40,   1, 64'h3C,   w(64'h3C),    0);
    add(0, 0, 0, 0, X64,          X64,                    X64,       64'h44,   1, 64'h40,   w(64'h40),    0);
    add(0, 0, 1, 1, X64,          X64,                    64'h3002,  64'h44,   0, 64'h0,    INSTR_NOP,    1);
    add(0, 0, 1, 1, X64,          X64,                    64'h4000,  64'h44,   0, 64'h0,    INSTR_NOP,    1);
    add(0, 0, 0, 0, X64,          X64,                    X64,       64'h44,   0, 64'h0,    INSTR_NOP,    1);
    add(0, 1, 0, 0, X64,          X64,                    X64,       64'h44,   0, 64'h0,    INSTR_NOP,    1);
    add(1, 0, 0, 0, X64,          X64,                    X64,       RPC,      0, 64'h0,    INSTR_NOP,    0);
    add(0, 0, 0, 0, X64,          X64,                    X64,       64'h1004, 1, 64'h1000, w(64'h1000),  0);
    add(1, 1, 1, 1, X64,          X64,                    64'h8000,  RPC,      0, 64'h0,    INSTR_NOP,    0);
    add(0, 0, 0, 0, X64,          X64,                    X64,       64'h1004, 1, 64'h1000, w(64'h1000),  0);
    // Offset bits 63:62 fall off the word scaling: 0x100 + 4 = 0x104.
    add(0, 0, 1, 0, 64'h100,      64'h4000_0000_0000_0001, X64,      64'h104,  0, 64'h0,    INSTR_NOP,    0);
    add(0, 0, 1, 0, 64'h2002,     64'h1,                  X64,       64'h104,  0, 64'h0,    INSTR_NOP,    1);
    add(1, 0, 0, 0, X64,          X64,                    X64,       RPC,      0, 64'h0,    INSTR_NOP,    0);
    add(0, 0, 0, 0, X64,          X64,                    X64,       64'h1004, 1, 64'h1000, w(64'h1000),  0);

    foreach (vecs[i]) begin
      reset      = vecs[i].rst;
      stall      = vecs[i].stl;
      br_taken   = vecs[i].br;
      br_use_reg = vecs[i].ur;
      br_base    = vecs[i].base;
      br_offset  = vecs[i].off;
      br_reg     = vecs[i].breg;
      push_exp(vecs[i].addr, vecs[i].v, vecs[i].pc, vecs[i].instr, vecs[i].f);
      @(posedge clk);
      #1;
      sample($sformatf("vec%0d", i));
    end

    // Redirect inputs change mid-cycle; imem_addr must not move until the edge.
    reset = 1'b0; stall = 1'b0; br_taken = 1'b1; br_use_reg = 1'b1; br_reg = 64'h5000;
    #2;
    chk("midcycle.imem_addr", imem_addr, 64'h1004);
    push_exp(64'h5000, 1'b0, 64'h0, INSTR_NOP, 1'b0);
    @(posedge clk);
    #1;
    sample("redir.bubble");
    br_taken = 1'b0; br_reg = X64;
    push_exp(64'h5004, 1'b1, 64'h5000, w(64'h5000), 1'b0);
    @(posedge clk);
    #1;
    sample("redir.target");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
